grid_renderer: RTL and testbench

GRID_RENDERER -- requirements
Module: grid_renderer

---
 rtl/grid_renderer.sv | 211 +++++++++++++++++++++
 tb/tb_grid_renderer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_renderer.sv
// VGA renderer for an N x N grid of coloured cells with a blinking cursor outline.
// Frame inputs are captured into shadow registers at each frame wrap so a frame is drawn from one snapshot.
module grid_renderer #(
    parameter int unsigned GRID_N       = 3,
    parameter int unsigned CELL_W       = 189,
    parameter int unsigned CELL_H       = 139,
    parameter int unsigned GAP          = 21,
    parameter int unsigned ORIGIN_X     = 11,
    parameter int unsigned ORIGIN_Y     = 11,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned BORDER       = 4,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33
) (
    input  logic                                   CLK,
    input  logic                                   RST_BTN,
    input  logic [GRID_N*GRID_N-1:0]               RED,
    input  logic [GRID_N*GRID_N-1:0]               GREEN,
    input  logic [GRID_N*GRID_N-1:0]               BLUE,
    input  logic [((GRID_N*GRID_N > 1) ? $clog2(GRID_N*GRID_N) : 1)-1:0] CURSOR,
    input  logic                                   CURSOR_EN,
    output logic                                   VGA_HS_O,
    output logic                                   VGA_VS_O,
    output logic [3:0]                             VGA_R,
    output logic [3:0]                             VGA_G,
    output logic [3:0]                             VGA_B,
    output logic                                   FRAME_START
);

    localparam int unsigned NN       = GRID_N * GRID_N;
    localparam int unsigned CUR_W    = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FC_W     = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned PITCH_X  = CELL_W + GAP;
    localparam int unsigned PITCH_Y  = CELL_H + GAP;

    logic [DIV_W-1:0] div_q, div_d;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             blink_q, blink_d;
    logic [NN-1:0]    red_sh_q, red_sh_d;
    logic [NN-1:0]    green_sh_q, green_sh_d;
    logic [NN-1:0]    blue_sh_q, blue_sh_d;
    logic [CUR_W-1:0] cursor_sh_q, cursor_sh_d;
    logic             cursor_en_sh_q, cursor_en_sh_d;
    logic [3:0]       vga_r_q, vga_r_d;
    logic [3:0]       vga_g_q, vga_g_d;
    logic [3:0]       vga_b_q, vga_b_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frame_start_q, frame_start_d;

    logic             strobe_c;
    logic             h_last_c;
    logic             v_last_c;
    logic             wrap_c;
    logic             pix_r_c;
    logic             pix_g_c;
    logic             pix_b_c;
    logic             cur_edge_c;
    int unsigned      px_c;
    int unsigned      py_c;
    int unsigned      x0_c;
    int unsigned      y0_c;

    assign strobe_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_last_c = (h_q == HW'(H_TOTAL - 1));
    assign v_last_c = (v_q == VW'(V_TOTAL - 1));
    assign wrap_c   = h_last_c && v_last_c;

    // Cell hit test by per-row/per-column comparators against the current counters.
    always_comb begin
        px_c       = 32'(h_q);
        py_c       = 32'(v_q);
        x0_c       = 0;
        y0_c       = 0;
        pix_r_c    = 1'b0;
        pix_g_c    = 1'b0;
        pix_b_c    = 1'b0;
        cur_edge_c = 1'b0;
        if (px_c < H_ACTIVE && py_c < V_ACTIVE) begin
            for (int unsigned r = 0; r < GRID_N; r++) begin
                y0_c = ORIGIN_Y + r * PITCH_Y;
                for (int unsigned c = 0; c < GRID_N; c++) begin
                    x0_c = ORIGIN_X + c * PITCH_X;
                    if (py_c >= y0_c && py_c < y0_c + CELL_H &&
                        px_c >= x0_c && px_c < x0_c + CELL_W) begin
                        pix_r_c = pix_r_c | red_sh_q[NN - 1 - (r * GRID_N + c)];
                        pix_g_c = pix_g_c | green_sh_q[NN - 1 - (r * GRID_N + c)];
                        pix_b_c = pix_b_c | blue_sh_q[NN - 1 - (r * GRID_N + c)];
                        // Out-of-range cursor values never match a cell index.
                        if (cursor_en_sh_q && !blink_q &&
                            32'(cursor_sh_q) == r * GRID_N + c &&
                            (px_c <  x0_c + BORDER || px_c >= x0_c + CELL_W - BORDER ||
                             py_c <  y0_c + BORDER || py_c >= y0_c + CELL_H - BORDER)) begin
                            cur_edge_c = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Timing counters, shadow capture, blink and output pipeline; all advance on the strobe.
    always_comb begin
        div_d          = div_q + DIV_W'(1);
        h_d            = h_q;
        v_d            = v_q;
        fcnt_d         = fcnt_q;
        blink_d        = blink_q;
        red_sh_d       = red_sh_q;
        green_sh_d     = green_sh_q;
        blue_sh_d      = blue_sh_q;
        cursor_sh_d    = cursor_sh_q;
        cursor_en_sh_d = cursor_en_sh_q;
        vga_r_d        = vga_r_q;
        vga_g_d        = vga_g_q;
        vga_b_d        = vga_b_q;
        hs_d           = hs_q;
        vs_d           = vs_q;
        frame_start_d  = 1'b0;
        if (strobe_c) begin
            div_d   = '0;
            h_d     = h_last_c ? '0 : h_q + HW'(1);
            if (h_last_c) begin
                v_d = v_last_c ? '0 : v_q + VW'(1);
            end
            vga_r_d = cur_edge_c ? 4'hF : {4{pix_r_c}};
            vga_g_d = cur_edge_c ? 4'hF : {4{pix_g_c}};
            vga_b_d = cur_edge_c ? 4'hF : {4{pix_b_c}};
            hs_d    = !(px_c >= HS_START && px_c < HS_END);
            vs_d    = !(py_c >= VS_START && py_c < VS_END);
            if (wrap_c) begin
                red_sh_d       = RED;
                green_sh_d     = GREEN;
                blue_sh_d      = BLUE;
                cursor_sh_d    = CURSOR;
                cursor_en_sh_d = CURSOR_EN;
                frame_start_d  = 1'b1;
                if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    fcnt_d  = '0;
                    blink_d = !blink_q;
                end else begin
                    fcnt_d  = fcnt_q + FC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            div_q          <= '0;
            h_q            <= '0;
            v_q            <= '0;
            fcnt_q         <= '0;
            blink_q        <= 1'b0;
            red_sh_q       <= '0;
            green_sh_q     <= '0;
            blue_sh_q      <= '0;
            cursor_sh_q    <= '0;
            cursor_en_sh_q <= 1'b0;
            vga_r_q        <= 4'h0;
            vga_g_q        <= 4'h0;
            vga_b_q        <= 4'h0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            div_q          <= div_d;
            h_q            <= h_d;
            v_q            <= v_d;
            fcnt_q         <= fcnt_d;
            blink_q        <= blink_d;
            red_sh_q       <= red_sh_d;
            green_sh_q     <= green_sh_d;
            blue_sh_q      <= blue_sh_d;
            cursor_sh_q    <= cursor_sh_d;
            cursor_en_sh_q <= cursor_en_sh_d;
            vga_r_q        <= vga_r_d;
            vga_g_q        <= vga_g_d;
            vga_b_q        <= vga_b_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign VGA_R       = vga_r_q;
    assign VGA_G       = vga_g_q;
    assign VGA_B       = vga_b_q;
    assign VGA_HS_O    = hs_q;
    assign VGA_VS_O    = vs_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer on a shrunken raster (56x36 strobes/frame, 3x3 cells of 8x6).
module tb_grid_renderer;

    localparam int HT    = 56;
    localparam int VT    = 36;
    localparam int NPIX  = HT * VT;
    localparam int CDIV  = 2;
    localparam int CW    = 8;
    localparam int CH    = 6;
    localparam int BRD   = 2;

    logic       clk;
    logic       rst_btn;
    logic [8:0] red, green, blue;
    logic [3:0] cursor;
    logic       cursor_en;
    logic       hs, vs, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;

    logic [3:0] fr_r [NPIX];
    logic [3:0] fr_g [NPIX];
    logic [3:0] fr_b [NPIX];
    logic       fr_hs[NPIX];
    logic       fr_vs[NPIX];

    int tests  = 0;
    int failed = 0;

    grid_renderer #(
        .GRID_N(3), .CELL_W(CW), .CELL_H(CH), .GAP(3), .ORIGIN_X(2), .ORIGIN_Y(2),
        .CLK_DIV(CDIV), .BORDER(BRD), .BLINK_FRAMES(2),
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .CLK(clk), .RST_BTN(rst_btn), .RED(red), .GREEN(green), .BLUE(blue),
        .CURSOR(cursor), .CURSOR_EN(cursor_en), .VGA_HS_O(hs), .VGA_VS_O(vs),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .FRAME_START(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mismatching pixels of one captured channel against hand-placed cells x{2,13,24} y{2,11,20}.
    function automatic int mism(input int ch, input logic [8:0] occ, input int cur, input bit cur_on);
        int n = 0;
        int cx[3] = '{2, 13, 24};
        int ry[3] = '{2, 11, 20};
        for (int k = 0; k < NPIX; k++) begin
            int x = k % HT;
            int y = k / HT;
            logic [3:0] e = 4'h0;
            logic [3:0] o;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (x >= cx[c] && x < cx[c] + CW && y >= ry[r] && y < ry[r] + CH) begin
                        if (occ[8 - (r * 3 + c)]) e = 4'hF;
                        if (cur_on && cur == r * 3 + c &&
                            (x < cx[c] + BRD || x >= cx[c] + CW - BRD ||
                             y < ry[r] + BRD || y >= ry[r] + CH - BRD)) e = 4'hF;
                    end
                end
            end
            o = (ch == 0) ? fr_r[k] : (ch == 1) ? fr_g[k] : fr_b[k];
            if (o !== e) n++;
        end
        return n;
    endfunction

    // Record one frame of strobes; optional mid-frame input change at sample chg_k.
    task automatic capture(input int chg_k, input logic [8:0] nr, input logic [8:0] ng,
                           input logic [8:0] nb);
        int fs_bad = 0;
        for (int k = 0; k < NPIX; k++) begin
            if (k == chg_k) begin
                red = nr; green = ng; blue = nb;
            end
            repeat (CDIV) @(posedge clk);
            #1;
            fr_r[k] = vga_r; fr_g[k] = vga_g; fr_b[k] = vga_b;
            fr_hs[k] = hs;   fr_vs[k] = vs;
            if ((frame_start === 1'b1) != (k == NPIX - 1)) fs_bad++;
        end
        chk("frame_start_period", fs_bad, 0);
    endtask

    task automatic grab_frame(input int chg_k, input logic [8:0] nr, input logic [8:0] ng,
                              input logic [8:0] nb);
        int budget = 4 * NPIX * CDIV;
        while (frame_start !== 1'b1 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("frame_start_wait", int'(frame_start === 1'b1), 1);
        capture(chg_k, nr, ng, nb);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_r"}, int'(vga_r), 0);
        chk({tag, "_g"}, int'(vga_g), 0);
        chk({tag, "_b"}, int'(vga_b), 0);
        chk({tag, "_hs"}, int'(hs), 1);
        chk({tag, "_vs"}, int'(vs), 1);
        chk({tag, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        int hs_low;
        int vs_low;
        rst_btn = 1'b0; red = 9'b100000000; green = 9'h000; blue = 9'h000;
        cursor = 4'd0; cursor_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Frame 0 after release is black; the wrap lands exactly NPIX strobes later.
        rst_btn = 1'b1;
        capture(-1, 9'h000, 9'h000, 9'h000);
        chk("f0_black", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);

        // F1: red cell 0 only; inputs go white at v=15 without affecting this frame.
        grab_frame(15 * HT, 9'h1FF, 9'h1FF, 9'h1FF);
        chk("f1_red", mism(0, 9'h100, 0, 0), 0);
        chk("f1_green", mism(1, 9'h000, 0, 0), 0);
        chk("f1_blue", mism(2, 9'h000, 0, 0), 0);

        // F2: all white, plus sync placement.
        grab_frame(0, 9'h000, 9'h000, 9'h000);
        chk("f2_red", mism(0, 9'h1FF, 0, 0), 0);
        chk("f2_green", mism(1, 9'h1FF, 0, 0), 0);
        chk("f2_blue", mism(2, 9'h1FF, 0, 0), 0);
        chk("f2_px_2_2", int'(fr_r[2 * HT + 2]), 15);
        chk("f2_px_10_2", int'(fr_r[2 * HT + 10]), 0);
        chk("f2_px_1_2", int'(fr_r[2 * HT + 1]), 0);
        chk("f2_px_31_25", int'(fr_b[25 * HT + 31]), 15);
        chk("f2_px_32_25", int'(fr_b[25 * HT + 32]), 0);
        hs_low = 0;
        for (int x = 0; x < HT; x++) if (fr_hs[5 * HT + x] == 1'b0) hs_low++;
        chk("hs_low_per_line", hs_low, 6);
        chk("hs_at_43", int'(fr_hs[5 * HT + 43]), 1);
        chk("hs_at_44", int'(fr_hs[5 * HT + 44]), 0);
        chk("hs_at_49", int'(fr_hs[5 * HT + 49]), 0);
        chk("hs_at_50", int'(fr_hs[5 * HT + 50]), 1);
        vs_low = 0;
        for (int y = 0; y < VT; y++) if (fr_vs[y * HT] == 1'b0) vs_low++;
        chk("vs_low_lines", vs_low, 2);
        chk("vs_at_31", int'(fr_vs[31 * HT]), 1);
        chk("vs_at_32", int'(fr_vs[32 * HT]), 0);
        chk("vs_at_34", int'(fr_vs[34 * HT]), 1);

        // F3: boards cleared; red cell 4 arrives mid-frame and must wait for the wrap.
        grab_frame(15 * HT, 9'h010, 9'h000, 9'h000);
        chk("f3_hold", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);

        cursor = 4'd4; cursor_en = 1'b1;
        grab_frame(0, 9'h000, 9'h000, 9'h000);
        chk("f4_red_cell4", mism(0, 9'h010, 0, 0), 0);
        chk("f4_gb_zero", mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);

        // Blink phase: on in F5, off in F6/F7, on in F8.
        grab_frame(-1, 9'h000, 9'h000, 9'h000);
        chk("f5_cur_r", mism(0, 9'h000, 4, 1), 0);
        chk("f5_cur_g", mism(1, 9'h000, 4, 1), 0);
        chk("f5_cur_b", mism(2, 9'h000, 4, 1), 0);
        chk("f5_cur_corner", int'(fr_g[11 * HT + 13]), 15);
        chk("f5_cur_inner", int'(fr_g[13 * HT + 15]), 0);
        grab_frame(-1, 9'h000, 9'h000, 9'h000);
        chk("f6_off", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);
        grab_frame(0, 9'h010, 9'h000, 9'h000);
        chk("f7_off", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);

        cursor = 4'd9;
        grab_frame(0, 9'h000, 9'h000, 9'h000);
        chk("f8_red_over", mism(0, 9'h010, 4, 1), 0);
        chk("f8_green_edge", mism(1, 9'h000, 4, 1), 0);
        chk("f8_blue_edge", mism(2, 9'h000, 4, 1), 0);

        // F9: cursor index 9 is out of range, boards empty -> nothing lit.
        grab_frame(0, 9'h1FF, 9'h1FF, 9'h1FF);
        chk("f9_oor", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);

        // Mid-frame reset at pixel (30,20) of a white frame.
        for (int j = 1; j <= 20 * HT + 31; j++) begin
            repeat (CDIV) @(posedge clk);
            #1;
        end
        chk("pre_rst_px", int'(vga_r), 15);
        rst_btn = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst_btn = 1'b1;
        capture(-1, 9'h1FF, 9'h1FF, 9'h1FF);
        chk("rst_black", mism(0, 9'h000, 0, 0) + mism(1, 9'h000, 0, 0) + mism(2, 9'h000, 0, 0), 0);
        grab_frame(-1, 9'h1FF, 9'h1FF, 9'h1FF);
        chk("rst_resume", mism(0, 9'h1FF, 0, 0) + mism(1, 9'h1FF, 0, 0) + mism(2, 9'h1FF, 0, 0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
